cmple_serial_stage: RTL
=======================

// Module: cmple_serial_stage
// PURPOSE
//  Bit-serial unsigned "a <= b" comparator stage with valid/ready handshakes on
//  both sides. It is the sequential counterpart of the combinational multibit
//  cmple gate, and it sits in the same operand path.
//  It accepts one operand pair and scans MSB-first, one bit per clock, stopping
//  early at the first differing bit. The result is held until the downstream
//  consumer takes it.
// PARAMETERS
//  WIDTH  4  operand width in bits (>= 2)
//  CW     $clog2(WIDTH+1)  width of nbits (derived; do not override)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      reset, asynchronous, active-low
//  in_valid   in   1      operand pair a/b valid
//  in_ready   out  1      stage can accept a pair (high only in IDLE)
//  a          in   WIDTH  left operand, unsigned
//  b          in   WIDTH  right operand, unsigned
//  out_valid  out  1      le/eq/nbits hold a result
//  out_ready  in   1      consumer takes the result
//  le         out  1      1 when a <= b
//  eq         out  1      1 when a == b
//  nbits      out  CW     number of bit positions examined (1..WIDTH)
// BEHAVIOUR
//  Clock and reset: one clock domain. rst_n is asynchronous, active-low.
//  Reset values: state=IDLE, in_ready=1, out_valid=0, le=0, eq=0, nbits=0;
//  internal operand regs and idx are cleared to 0.
//  All outputs are registered. in_ready is decoded from state (IDLE).
//  FSM states: IDLE, SCAN, HOLD.
//  IDLE:
//   - in_valid & in_ready: latch a and b, set idx=WIDTH-1, clear nbits, go to SCAN.
//   - Otherwise stay in IDLE.
//  SCAN: each cycle, compare a_q[idx] with b_q[idx] and increment nbits.
//   - Bits differ: le = b_q[idx], eq = 0, go to HOLD.
//   - Bits equal and idx == 0: le = 1, eq = 1, go to HOLD.
//   - Bits equal and idx > 0: decrement idx, stay in SCAN.
//  HOLD: out_valid = 1.
//   - out_ready: go to IDLE. out_valid drops on the same edge.
//   - Otherwise le, eq and nbits are held stable.
//  Latency: accept edge T0. First differing bit k (MSB = WIDTH-1) is found at
//  edge T0 + (WIDTH-k), and out_valid is high after that edge.
//   - Equal operands: WIDTH scan cycles.
//   - Best case (MSB differs): out_valid after T0+1.
//  Throughput: no overlap. A new pair is accepted only once the stage is back in
//  IDLE. in_valid while busy is ignored, and the upstream must hold its data
//  until in_ready is high.
//  Simultaneous events:
//   - out_ready with out_valid=0: ignored.
//   - in_valid in HOLD: ignored, even if out_ready is high the same cycle.
//  Reset during operation: rst_n low in SCAN or HOLD returns the stage to IDLE
//  immediately, with reset output values. A partially scanned pair is discarded.
//  Arithmetic: unsigned only. le matches the combinational gate:
//  le = ~(a > b) for all 2^(2*WIDTH) pairs.
//  No X on outputs after reset, whatever the input values.
// TESTING (WIDTH=4)
//  1. Reset: rst_n=0 -> in_ready=1, out_valid=0, le=0, eq=0, nbits=0.
//  2. a=4'h3, b=4'h9 -> out_valid after 1 scan cycle; le=1, eq=0, nbits=1.
//  3. a=b=4'hA -> out_valid after 4 scan cycles; le=1, eq=1, nbits=4.
//  4. a=4'h7, b=4'h6 -> le=0, eq=0, nbits=4.
//  5. Backpressure: out_ready=0 for 5 cycles in HOLD, then 1.
//     - le/eq/nbits stay stable and in_ready=0 throughout.
//     - A pulsed in_valid during HOLD is not accepted.
//  6. rst_n pulsed low mid-SCAN of a=4'h8, b=4'h8: outputs return to reset values
//     at once. The next pair a=4'hF, b=4'h0 then gives le=0, nbits=1.
//  Exhaustive: all 256 pairs with random in_valid/out_ready gaps; compare
//  le/eq against a <= b and a == b.

Source files
------------

// File: rtl/cmple_serial_stage_if.sv
// Handshake bundle for the bit-serial a <= b comparator stage.
// The master side supplies operands and consumes results; the slave is the stage.
interface cmple_serial_stage_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             le;
    logic             eq;
    logic [CW-1:0]    nbits;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, le, eq, nbits
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, le, eq, nbits
    );
endinterface

// File: rtl/cmple_serial_stage.sv
// Bit-serial unsigned a <= b comparator: scans MSB-first, one bit per clock,
// stops at the first differing bit and holds the result until it is taken.
module cmple_serial_stage #(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned CW = $clog2(WIDTH + 1)
) (
    input logic                 clk,
    input logic                 rst_n,
    cmple_serial_stage_if.slave bus_io
);
    localparam int unsigned IW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StScan, StHold} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx_q;
    logic [CW-1:0]    nbits_q;
    logic             le_q;
    logic             eq_q;
    logic             out_valid_q;

    logic a_bit;
    logic b_bit;

    assign a_bit = a_q[idx_q];
    assign b_bit = b_q[idx_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            nbits_q     <= '0;
            le_q        <= 1'b0;
            eq_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.in_valid) begin
                        a_q     <= bus_io.a;
                        b_q     <= bus_io.b;
                        idx_q   <= IW'(WIDTH - 1);
                        nbits_q <= '0;
                        state_q <= StScan;
                    end
                end
                StScan: begin
                    nbits_q <= nbits_q + CW'(1);
                    if (a_bit != b_bit) begin
                        // First differing bit decides: a <= b exactly when b has the 1.
                        le_q        <= b_bit;
                        eq_q        <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= StHold;
                    end else if (idx_q == '0) begin
                        le_q        <= 1'b1;
                        eq_q        <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= StHold;
                    end else begin
                        idx_q <= idx_q - IW'(1);
                    end
                end
                StHold: begin
                    if (bus_io.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.in_ready  = (state_q == StIdle);
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.le        = le_q;
    assign bus_io.eq        = eq_q;
    assign bus_io.nbits     = nbits_q;
endmodule
